rib_arb2: RTL and testbench

Two-master arbiter for the RIB bus. It shares one RIB slave port between the core's instruction-fetch master (port 0, ibus) and data-access master (port 1, dbus). The block sits between the core's two RIB master ports and a single memory/interconnect slave. It runs one transaction at a time: grant, address phase, response phase. Arbitration is either round-robin or fixed priority.

---
 rtl/rib_arb2.sv | 154 +++++++++++++++
 tb/tb_rib_arb2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rib_arb2.sv
// Two-master RIB arbiter: shares one slave port between ibus (master 0) and dbus (master 1),
// one transaction at a time (IDLE -> ADDR -> RESP), round-robin or fixed-priority on ties.
module rib_arb2 #(
    parameter bit P_RR = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_ribs_addr0,
    input  logic        i_ribs_wrcs0,
    input  logic [3:0]  i_ribs_mask0,
    input  logic [31:0] i_ribs_wdata0,
    input  logic        i_ribs_req0,
    output logic        o_ribs_gnt0,
    output logic [31:0] o_ribs_rdata0,
    output logic        o_ribs_rsp0,
    input  logic        i_ribs_rdy0,
    input  logic [31:0] i_ribs_addr1,
    input  logic        i_ribs_wrcs1,
    input  logic [3:0]  i_ribs_mask1,
    input  logic [31:0] i_ribs_wdata1,
    input  logic        i_ribs_req1,
    output logic        o_ribs_gnt1,
    output logic [31:0] o_ribs_rdata1,
    output logic        o_ribs_rsp1,
    input  logic        i_ribs_rdy1,
    output logic [31:0] o_ribm_addr,
    output logic        o_ribm_wrcs,
    output logic [3:0]  o_ribm_mask,
    output logic [31:0] o_ribm_wdata,
    output logic        o_ribm_req,
    input  logic        i_ribm_gnt,
    input  logic [31:0] i_ribm_rdata,
    input  logic        i_ribm_rsp,
    output logic        o_ribm_rdy,
    output logic        o_owner,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last, last_nxt;
    logic   winner;

    logic        own_req;
    logic        own_rdy;
    logic [31:0] own_addr;
    logic        own_wrcs;
    logic [3:0]  own_mask;
    logic [31:0] own_wdata;

    assign own_req   = owner ? i_ribs_req1   : i_ribs_req0;
    assign own_rdy   = owner ? i_ribs_rdy1   : i_ribs_rdy0;
    assign own_addr  = owner ? i_ribs_addr1  : i_ribs_addr0;
    assign own_wrcs  = owner ? i_ribs_wrcs1  : i_ribs_wrcs0;
    assign own_mask  = owner ? i_ribs_mask1  : i_ribs_mask0;
    assign own_wdata = owner ? i_ribs_wdata1 : i_ribs_wdata0;

    // On a tie round-robin favours whoever did not finish last; fixed priority favours dbus.
    always_comb begin
        if (i_ribs_req0 && i_ribs_req1)
            winner = P_RR ? ~last : 1'b1;
        else
            winner = i_ribs_req1;
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (i_ribs_req0 || i_ribs_req1) begin
                    owner_nxt = winner;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (own_req && i_ribm_gnt) begin
                    state_nxt = RESP;
                    last_nxt  = owner;
                end else if (!own_req) begin
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                if (i_ribm_rsp && own_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    // Outputs are forced low while reset is asserted, even before the state register settles.
    always_comb begin
        o_ribs_gnt0   = 1'b0;
        o_ribs_gnt1   = 1'b0;
        o_ribs_rdata0 = '0;
        o_ribs_rdata1 = '0;
        o_ribs_rsp0   = 1'b0;
        o_ribs_rsp1   = 1'b0;
        o_ribm_addr   = '0;
        o_ribm_wrcs   = 1'b0;
        o_ribm_mask   = '0;
        o_ribm_wdata  = '0;
        o_ribm_req    = 1'b0;
        o_ribm_rdy    = 1'b0;
        o_owner       = 1'b0;
        o_busy        = 1'b0;
        if (!i_rst) begin
            o_owner = owner;
            o_busy  = (state != IDLE);
            case (state)
                ADDR: begin
                    o_ribm_addr  = own_addr;
                    o_ribm_wrcs  = own_wrcs;
                    o_ribm_mask  = own_mask;
                    o_ribm_wdata = own_wdata;
                    o_ribm_req   = own_req;
                    o_ribs_gnt0  = ~owner & i_ribm_gnt;
                    o_ribs_gnt1  =  owner & i_ribm_gnt;
                end
                RESP: begin
                    o_ribs_rsp0   = ~owner & i_ribm_rsp;
                    o_ribs_rsp1   =  owner & i_ribm_rsp;
                    o_ribs_rdata0 = owner ? 32'd0 : i_ribm_rdata;
                    o_ribs_rdata1 = owner ? i_ribm_rdata : 32'd0;
                    o_ribm_rdy    = own_rdy;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_arb2.sv
// Self-checking bench for rib_arb2: a round-robin and a fixed-priority instance share one stimulus
// stream and are compared every cycle against a transaction-level reference model.
module tb_rib_arb2;

    logic        i_clk = 1'b0;
    logic        rst;
    logic [31:0] s_addr  [2];
    logic        s_wrcs  [2];
    logic [3:0]  s_mask  [2];
    logic [31:0] s_wdata [2];
    logic        s_req   [2];
    logic        s_rdy   [2];
    logic        sl_gnt;
    logic [31:0] sl_rdata;
    logic        sl_rsp;

    logic        o_gnt0 [2], o_gnt1 [2], o_rsp0 [2], o_rsp1 [2];
    logic [31:0] o_rdata0 [2], o_rdata1 [2];
    logic [31:0] o_addr [2], o_wdata [2];
    logic        o_wrcs [2], o_req [2], o_rdy [2], o_own [2], o_busy [2];
    logic [3:0]  o_mask [2];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: phase 0 = idle, 1 = address phase, 2 = response phase.
    int md_phase [2];
    int md_owner [2];
    int md_last  [2];
    int bq [$];

    always #5 i_clk = ~i_clk;

    rib_arb2 #(.P_RR(1'b1)) dut_rr (
        .i_clk(i_clk), .i_rst(rst),
        .i_ribs_addr0(s_addr[0]), .i_ribs_wrcs0(s_wrcs[0]), .i_ribs_mask0(s_mask[0]),
        .i_ribs_wdata0(s_wdata[0]), .i_ribs_req0(s_req[0]), .o_ribs_gnt0(o_gnt0[0]),
        .o_ribs_rdata0(o_rdata0[0]), .o_ribs_rsp0(o_rsp0[0]), .i_ribs_rdy0(s_rdy[0]),
        .i_ribs_addr1(s_addr[1]), .i_ribs_wrcs1(s_wrcs[1]), .i_ribs_mask1(s_mask[1]),
        .i_ribs_wdata1(s_wdata[1]), .i_ribs_req1(s_req[1]), .o_ribs_gnt1(o_gnt1[0]),
        .o_ribs_rdata1(o_rdata1[0]), .o_ribs_rsp1(o_rsp1[0]), .i_ribs_rdy1(s_rdy[1]),
        .o_ribm_addr(o_addr[0]), .o_ribm_wrcs(o_wrcs[0]), .o_ribm_mask(o_mask[0]),
        .o_ribm_wdata(o_wdata[0]), .o_ribm_req(o_req[0]), .i_ribm_gnt(sl_gnt),
        .i_ribm_rdata(sl_rdata), .i_ribm_rsp(sl_rsp), .o_ribm_rdy(o_rdy[0]),
        .o_owner(o_own[0]), .o_busy(o_busy[0])
    );

    rib_arb2 #(.P_RR(1'b0)) dut_fp (
        .i_clk(i_clk), .i_rst(rst),
        .i_ribs_addr0(s_addr[0]), .i_ribs_wrcs0(s_wrcs[0]), .i_ribs_mask0(s_mask[0]),
        .i_ribs_wdata0(s_wdata[0]), .i_ribs_req0(s_req[0]), .o_ribs_gnt0(o_gnt0[1]),
        .o_ribs_rdata0(o_rdata0[1]), .o_ribs_rsp0(o_rsp0[1]), .i_ribs_rdy0(s_rdy[0]),
        .i_ribs_addr1(s_addr[1]), .i_ribs_wrcs1(s_wrcs[1]), .i_ribs_mask1(s_mask[1]),
        .i_ribs_wdata1(s_wdata[1]), .i_ribs_req1(s_req[1]), .o_ribs_gnt1(o_gnt1[1]),
        .o_ribs_rdata1(o_rdata1[1]), .o_ribs_rsp1(o_rsp1[1]), .i_ribs_rdy1(s_rdy[1]),
        .o_ribm_addr(o_addr[1]), .o_ribm_wrcs(o_wrcs[1]), .o_ribm_mask(o_mask[1]),
        .o_ribm_wdata(o_wdata[1]), .o_ribm_req(o_req[1]), .i_ribm_gnt(sl_gnt),
        .i_ribm_rdata(sl_rdata), .i_ribm_rsp(sl_rsp), .o_ribm_rdy(o_rdy[1]),
        .o_owner(o_own[1]), .o_busy(o_busy[1])
    );

    function automatic logic [140:0] observed(input int m);
        return {o_gnt0[m], o_gnt1[m], o_rdata0[m], o_rdata1[m], o_rsp0[m], o_rsp1[m],
                o_addr[m], o_wrcs[m], o_mask[m], o_wdata[m], o_req[m], o_rdy[m],
                o_own[m], o_busy[m]};
    endfunction

    function automatic logic [140:0] expected(input int m);
        logic        g0 = 0, g1 = 0, r0 = 0, r1 = 0, wr = 0, rq = 0, rd = 0, ow = 0, bz = 0;
        logic [31:0] d0 = 0, d1 = 0, ad = 0, wd = 0;
        logic [3:0]  mk = 0;
        int          o;
        if (!rst) begin
            o  = md_owner[m];
            ow = (o == 1);
            bz = (md_phase[m] != 0);
            if (md_phase[m] == 1) begin
                ad = s_addr[o]; wr = s_wrcs[o]; mk = s_mask[o]; wd = s_wdata[o]; rq = s_req[o];
                if (o == 0) g0 = sl_gnt; else g1 = sl_gnt;
            end else if (md_phase[m] == 2) begin
                if (o == 0) begin r0 = sl_rsp; d0 = sl_rdata; end
                else        begin r1 = sl_rsp; d1 = sl_rdata; end
                rd = s_rdy[o];
            end
        end
        return {g0, g1, d0, d1, r0, r1, ad, wr, mk, wd, rq, rd, ow, bz};
    endfunction

    task automatic model_update(input int m);
        int o = md_owner[m];
        if (rst) begin
            md_phase[m] = 0; md_owner[m] = 0; md_last[m] = 1;
        end else if (md_phase[m] == 0) begin
            if (s_req[0] || s_req[1]) begin
                if (s_req[0] && s_req[1]) md_owner[m] = (m == 0) ? 1 - md_last[m] : 1;
                else                      md_owner[m] = s_req[1] ? 1 : 0;
                md_phase[m] = 1;
            end
        end else if (md_phase[m] == 1) begin
            if (s_req[o] && sl_gnt) begin md_phase[m] = 2; md_last[m] = o; end
            else if (!s_req[o])          md_phase[m] = 0;
        end else if (sl_rsp && s_rdy[o]) begin
            md_phase[m] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [140:0] got, input logic [140:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare both instances with the current inputs, then clock once and advance the model.
    task automatic step(input string tag);
        #1;
        check({tag, "_rr"}, observed(0), expected(0));
        check({tag, "_fp"}, observed(1), expected(1));
        @(posedge i_clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; sl_gnt = 0; sl_rdata = 0; sl_rsp = 0;
        for (int i = 0; i < 2; i++) begin
            s_addr[i] = 0; s_wrcs[i] = 0; s_mask[i] = 0; s_wdata[i] = 0; s_req[i] = 0; s_rdy[i] = 0;
        end
    endtask

    initial begin
        idle_inputs();
        md_phase = '{0, 0}; md_owner = '{0, 0}; md_last = '{1, 1};
        rst = 1;
        step("reset");
        step("reset");
        rst = 0;
        step("post_reset");

        // Single read from master 0
        s_req[0] = 1; s_addr[0] = 32'h8000_0000; s_rdy[0] = 1;
        step("rd_c0");
        sl_gnt = 1;
        step("rd_c1");
        sl_gnt = 0; s_req[0] = 0;
        step("rd_c2");
        sl_rsp = 1; sl_rdata = 32'hDEAD_BEEF;
        step("rd_c3");
        idle_inputs();
        step("rd_c4");
        check("rd_busy_fell", {140'd0, o_busy[0]}, 141'd0);

        // Write from master 1
        s_req[1] = 1; s_wrcs[1] = 1; s_mask[1] = 4'b0011; s_wdata[1] = 32'h1234_5678;
        s_addr[1] = 32'h0000_0040; s_rdy[1] = 1;
        step("wr_c0");
        sl_gnt = 1;
        check("wr_slave_sees", {o_req[0], o_wrcs[0], o_mask[0], o_wdata[0]},
              {104'd0, 1'b1, 1'b1, 4'b0011, 32'h1234_5678});
        step("wr_c1");
        sl_gnt = 0; s_req[1] = 0; sl_rsp = 1;
        step("wr_c2");
        idle_inputs();
        step("wr_c3");

        // Continuous contention: record the owner at every IDLE->busy transition.
        s_req[0] = 1; s_req[1] = 1; s_rdy[0] = 1; s_rdy[1] = 1; sl_gnt = 1; sl_rsp = 1;
        for (int m = 0; m < 2; m++) begin
            logic prev;
            logic [3:0] exp_seq;
            bq.delete();
            exp_seq = (m == 0) ? 4'b1010 : 4'b1111;
            for (int c = 0; c < 12; c++) begin
                prev = o_busy[m];
                step("tie");
                if (o_busy[m] && !prev) bq.push_back(int'(o_own[m]));
            end
            check("tie_count", 141'(bq.size()), 141'd4);
            for (int i = 0; i < bq.size() && i < 4; i++)
                check("tie_owner", 141'(bq[i]), 141'(exp_seq[i]));
        end
        idle_inputs();
        step("tie_drain");
        step("tie_drain");

        // Grant stall then response stall on master 0
        s_req[0] = 1; s_addr[0] = 32'h0000_1000;
        step("st_idle");
        for (int c = 0; c < 5; c++) step("st_gnt_wait");
        sl_gnt = 1;
        step("st_gnt");
        sl_gnt = 0; s_req[0] = 0; sl_rsp = 1; sl_rdata = 32'hA5A5_0F0F; s_rdy[0] = 0;
        for (int c = 0; c < 3; c++) step("st_rdy_wait");
        check("st_still_busy", {139'd0, o_busy[0], o_busy[1]}, {139'd0, 2'b11});
        s_rdy[0] = 1;
        step("st_done");
        idle_inputs();
        step("st_idle2");

        // Withdrawal in ADDR right after reset, then a tie
        rst = 1;
        step("wd_reset");
        rst = 0; s_req[0] = 1;
        step("wd_req");
        s_req[0] = 0;
        step("wd_drop");
        check("wd_idle", {139'd0, o_busy[0], o_busy[1]}, 141'd0);
        s_req[0] = 1; s_req[1] = 1;
        step("wd_tie");
        check("wd_tie_owner", {139'd0, o_own[0], o_own[1]}, {139'd0, 2'b01});
        idle_inputs();
        step("wd_abort");
        step("wd_idle2");

        // Reset while master 0 is in the response phase
        s_req[0] = 1;
        step("rr_req");
        sl_gnt = 1;
        step("rr_gnt");
        sl_gnt = 0; s_req[0] = 0; rst = 1;
        step("rr_reset");
        rst = 0;
        check("rr_all_zero", observed(0), 141'd0);
        s_req[0] = 1; s_req[1] = 1;
        step("rr_tie");
        check("rr_tie_owner", {139'd0, o_own[0], o_own[1]}, {139'd0, 2'b01});
        idle_inputs();
        step("rr_abort");

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < 2; i++) begin
                s_req[i]   = ($urandom_range(0, 9) < 6);
                s_rdy[i]   = ($urandom_range(0, 9) < 7);
                s_addr[i]  = $urandom;
                s_wdata[i] = $urandom;
                s_wrcs[i]  = 1'($urandom);
                s_mask[i]  = 4'($urandom);
            end
            sl_gnt   = 1'($urandom);
            sl_rsp   = 1'($urandom);
            sl_rdata = $urandom;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
